mc_ctrl: RTL and testbench

- Multicycle MIPS control unit: the producer side of the `aluop` interface consumed by the ALU.
- Decodes opcode and funct from the instruction register.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB steps and drives every datapath select and write enable, including `aluop` for each step.
- Stalls on a simple memory ready handshake. Sits between the IR and the shared datapath (PC, regfile, ALU, ALUOut, memory).

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_ctrl_funct_dec.sv | 32 +++
 rtl/mc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared encodings for the multicycle MIPS control unit:
//                opcodes, functs, ALU operation codes, states, select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // R-type functs (IR[5:0])
    localparam logic [5:0] c_fn_addu = 6'b100001;
    localparam logic [5:0] c_fn_subu = 6'b100011;
    localparam logic [5:0] c_fn_add  = 6'b100000;
    localparam logic [5:0] c_fn_and  = 6'b100100;
    localparam logic [5:0] c_fn_or   = 6'b100101;
    localparam logic [5:0] c_fn_slt  = 6'b101010;

    // ALU operation codes, shared with the ALU
    localparam logic [5:0] c_alu_addu = 6'b100001;
    localparam logic [5:0] c_alu_subu = 6'b100011;
    localparam logic [5:0] c_alu_add  = 6'b100000;
    localparam logic [5:0] c_alu_and  = 6'b100100;
    localparam logic [5:0] c_alu_or   = 6'b100101;
    localparam logic [5:0] c_alu_slt  = 6'b101010;
    localparam logic [5:0] c_alu_lui  = 6'b001111;

    // alu_src_a / alu_src_b / pc_src selects
    localparam logic       c_srca_pc     = 1'b0;
    localparam logic       c_srca_a      = 1'b1;
    localparam logic [1:0] c_srcb_b      = 2'd0;
    localparam logic [1:0] c_srcb_four   = 2'd1;
    localparam logic [1:0] c_srcb_imm    = 2'd2;
    localparam logic [1:0] c_srcb_br     = 2'd3;
    localparam logic [1:0] c_pc_alu      = 2'd0;
    localparam logic [1:0] c_pc_aluout   = 2'd1;
    localparam logic [1:0] c_pc_jump     = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_WB_R     = 4'd3,
        S_EXE_I    = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_LD    = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BR       = 4'd10,
        S_JMP      = 4'd11,
        S_ILL      = 4'd12
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_funct_dec.sv
// ============================================================================
//  Module      : mc_funct_dec
//  Description : Combinational R-type funct decoder -> {aluop, legal}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_funct_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [5:0] aluop,
    output logic       legal
);

    always_comb begin
        aluop = c_alu_addu;
        legal = 1'b1;
        case (funct)
            c_fn_addu: aluop = c_alu_addu;
            c_fn_subu: aluop = c_alu_subu;
            c_fn_add:  aluop = c_alu_add;
            c_fn_and:  aluop = c_alu_and;
            c_fn_or:   aluop = c_alu_or;
            c_fn_slt:  aluop = c_alu_slt;
            default:   legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multicycle MIPS control unit: state sequencing plus every
//                datapath select, write enable and ALU operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [5:0] aluop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       i_or_d,
    output logic       ill_inst,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_fn_aluop;
    logic       w_fn_legal;
    logic       w_pc_wr, w_ir_wr, w_reg_wr, w_mem_rd, w_mem_wr, w_ill;

    mc_funct_dec u_funct_dec (
        .funct (funct),
        .aluop (w_fn_aluop),
        .legal (w_fn_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        aluop      = c_alu_addu;
        alu_src_a  = c_srca_pc;
        alu_src_b  = c_srcb_b;
        ext_op     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = c_pc_alu;
        i_or_d     = 1'b0;
        w_pc_wr    = 1'b0;
        w_ir_wr    = 1'b0;
        w_reg_wr   = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_ill      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_rd  = 1'b1;
                alu_src_b = c_srcb_four;
                if (mem_ready) begin
                    w_ir_wr = 1'b1;
                    w_pc_wr = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b = c_srcb_br;
                case (op)
                    c_op_rtype: w_next = w_fn_legal ? S_EXE_R : S_ILL;
                    c_op_addiu,
                    c_op_ori,
                    c_op_lui:   w_next = S_EXE_I;
                    c_op_lw,
                    c_op_sw:    w_next = S_MEM_ADDR;
                    c_op_beq:   w_next = S_BR;
                    c_op_j:     w_next = S_JMP;
                    default:    w_next = S_ILL;
                endcase
            end
            S_EXE_R: begin
                alu_src_a = c_srca_a;
                aluop     = w_fn_aluop;
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_dst  = 1'b1;
                w_reg_wr = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXE_I: begin
                alu_src_a = c_srca_a;
                alu_src_b = c_srcb_imm;
                w_next    = S_WB_I;
                case (op)
                    c_op_ori: aluop  = c_alu_or;
                    c_op_lui: aluop  = c_alu_lui;
                    default:  ext_op = 1'b1;
                endcase
            end
            S_WB_I: begin
                w_reg_wr = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = c_srca_a;
                alu_src_b = c_srcb_imm;
                ext_op    = 1'b1;
                w_next    = (op == c_op_sw) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_rd = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_next = S_WB_LD;
            end
            S_WB_LD: begin
                mem_to_reg = 1'b1;
                w_reg_wr   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_wr = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BR: begin
                alu_src_a = c_srca_a;
                aluop     = c_alu_subu;
                pc_src    = c_pc_aluout;
                w_pc_wr   = zero;
                w_next    = S_FETCH;
            end
            S_JMP: begin
                pc_src  = c_pc_jump;
                w_pc_wr = 1'b1;
                w_next  = S_FETCH;
            end
            S_ILL: begin
                w_ill  = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset blocks every write, including a write still waiting on mem_ready
    assign pc_wr    = w_pc_wr  & ~rst;
    assign ir_wr    = w_ir_wr  & ~rst;
    assign reg_wr   = w_reg_wr & ~rst;
    assign mem_rd   = w_mem_rd & ~rst;
    assign mem_wr   = w_mem_wr & ~rst;
    assign ill_inst = w_ill    & ~rst;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Self-checking bench for mc_ctrl with an instruction-level
//                trace model, a vector table and reset corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    localparam logic [5:0] ALU_ADDU = 6'h21, ALU_SUBU = 6'h23, ALU_ADD = 6'h20,
                           ALU_AND  = 6'h24, ALU_OR   = 6'h25, ALU_SLT = 6'h2a,
                           ALU_LUI  = 6'h0f;
    localparam logic [5:0] OP_R = 6'h00, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                           OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [3:0] ST_FETCH = 0, ST_DECODE = 1, ST_EXE_R = 2, ST_WB_R = 3,
                           ST_EXE_I = 4, ST_WB_I = 5, ST_MADDR = 6, ST_MRD = 7,
                           ST_WBLD = 8, ST_MWR = 9, ST_BR = 10, ST_JMP = 11, ST_ILL = 12;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] aluop;
        logic       src_a;
        logic [1:0] src_b;
        logic       ext;
        logic       reg_dst;
        logic       m2r;
        logic [1:0] pc_src;
        logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ill;
    } outv_t;

    typedef struct {
        outv_t v;
        logic  mr;
    } step_t;

    typedef struct {
        logic [5:0] op, funct;
        logic       z;
        int         fs, ms;
        int         lat, regw, pcw, illc, mwr;
        logic [5:0] alu2;
        logic       ext2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] op, funct;
    logic [5:0] aluop;
    logic       alu_src_a, ext_op, reg_dst, mem_to_reg;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ill_inst;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;
    step_t tr_q[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src), .pc_wr(pc_wr),
        .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .i_or_d(i_or_d), .ill_inst(ill_inst), .state(state)
    );

    always #5 clk = ~clk;

    outv_t dut_v;
    assign dut_v = {state, aluop, alu_src_a, alu_src_b, ext_op, reg_dst, mem_to_reg,
                    pc_src, pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ill_inst};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outv_t base(input logic [3:0] st);
        outv_t v = '0;
        v.st    = st;
        v.aluop = ALU_ADDU;
        return v;
    endfunction

    function automatic logic [5:0] r_alu(input logic [5:0] f);
        case (f)
            6'h21: return ALU_ADDU;
            6'h23: return ALU_SUBU;
            6'h20: return ALU_ADD;
            6'h24: return ALU_AND;
            6'h25: return ALU_OR;
            6'h2a: return ALU_SLT;
            default: return 6'h3f;
        endcase
    endfunction

    task automatic push(input outv_t v, input logic mr);
        step_t s;
        s.v  = v;
        s.mr = mr;
        tr_q.push_back(s);
    endtask

    // Instruction-level model: the cycle-by-cycle output trace one instruction
    // produces, with memory waits of fs (fetch) and ms (data) cycles.
    task automatic build_trace(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input int fs, input int ms);
        outv_t v;
        bit r_ok;
        tr_q.delete();
        for (int i = 0; i <= fs; i++) begin
            v = base(ST_FETCH); v.mem_rd = 1; v.src_b = 1;
            if (i == fs) begin v.ir_wr = 1; v.pc_wr = 1; end
            push(v, i == fs);
        end
        v = base(ST_DECODE); v.src_b = 3; push(v, 1'($urandom));
        r_ok = (r_alu(f) != 6'h3f);
        if (o == OP_R && r_ok) begin
            v = base(ST_EXE_R); v.src_a = 1; v.aluop = r_alu(f); push(v, 1'($urandom));
            v = base(ST_WB_R); v.reg_dst = 1; v.reg_wr = 1; push(v, 1'($urandom));
        end else if (o == OP_ADDIU || o == OP_ORI || o == OP_LUI) begin
            v = base(ST_EXE_I); v.src_a = 1; v.src_b = 2;
            v.ext   = (o == OP_ADDIU);
            v.aluop = (o == OP_ORI) ? ALU_OR : (o == OP_LUI) ? ALU_LUI : ALU_ADDU;
            push(v, 1'($urandom));
            v = base(ST_WB_I); v.reg_wr = 1; push(v, 1'($urandom));
        end else if (o == OP_LW || o == OP_SW) begin
            v = base(ST_MADDR); v.src_a = 1; v.src_b = 2; v.ext = 1; push(v, 1'($urandom));
            for (int i = 0; i <= ms; i++) begin
                v = base(o == OP_LW ? ST_MRD : ST_MWR); v.i_or_d = 1;
                if (o == OP_LW) v.mem_rd = 1; else v.mem_wr = 1;
                push(v, i == ms);
            end
            if (o == OP_LW) begin
                v = base(ST_WBLD); v.m2r = 1; v.reg_wr = 1; push(v, 1'($urandom));
            end
        end else if (o == OP_BEQ) begin
            v = base(ST_BR); v.src_a = 1; v.aluop = ALU_SUBU; v.pc_src = 1; v.pc_wr = z;
            push(v, 1'($urandom));
        end else if (o == OP_J) begin
            v = base(ST_JMP); v.pc_src = 2; v.pc_wr = 1; push(v, 1'($urandom));
        end else begin
            v = base(ST_ILL); v.ill = 1; push(v, 1'($urandom));
        end
    endtask

    // Runs one instruction from FETCH (called just after a rising edge).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fs, input int ms,
                             output int lat, output int regw, output int pcw,
                             output int illc, output int mwr,
                             output logic [5:0] alu2, output logic ext2);
        build_trace(o, f, z, fs, ms);
        op = o; funct = f; zero = z;
        lat = tr_q.size(); regw = 0; pcw = 0; illc = 0; mwr = 0; alu2 = '0; ext2 = 0;
        for (int k = 0; k < lat; k++) begin
            mem_ready = tr_q[k].mr;
            @(negedge clk);
            check("trace", 32'(dut_v), 32'(tr_q[k].v));
            regw += int'(reg_wr); pcw += int'(pc_wr); illc += int'(ill_inst); mwr += int'(mem_wr);
            if (k == 2 + fs) begin alu2 = aluop; ext2 = ext_op; end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t tbl[$];
        int lat, regw, pcw, illc, mwr;
        logic [5:0] alu2;
        logic ext2;
        logic [5:0] ops[9];
        logic [5:0] fns[7];

        //            op      funct  z  fs ms  lat rw pw ill mw alu2      ext2
        tbl.push_back('{OP_R,     6'h21, 0, 0, 0, 4, 1, 1, 0, 0, ALU_ADDU, 0});
        tbl.push_back('{OP_R,     6'h23, 0, 0, 0, 4, 1, 1, 0, 0, ALU_SUBU, 0});
        tbl.push_back('{OP_R,     6'h20, 0, 0, 0, 4, 1, 1, 0, 0, ALU_ADD,  0});
        tbl.push_back('{OP_R,     6'h24, 0, 0, 0, 4, 1, 1, 0, 0, ALU_AND,  0});
        tbl.push_back('{OP_R,     6'h25, 0, 0, 0, 4, 1, 1, 0, 0, ALU_OR,   0});
        tbl.push_back('{OP_R,     6'h2a, 0, 0, 0, 4, 1, 1, 0, 0, ALU_SLT,  0});
        tbl.push_back('{OP_ORI,   6'h00, 0, 0, 0, 4, 1, 1, 0, 0, ALU_OR,   0});
        tbl.push_back('{OP_ADDIU, 6'h00, 0, 0, 0, 4, 1, 1, 0, 0, ALU_ADDU, 1});
        tbl.push_back('{OP_LUI,   6'h00, 0, 0, 0, 4, 1, 1, 0, 0, ALU_LUI,  0});
        tbl.push_back('{OP_LW,    6'h00, 0, 0, 3, 8, 1, 1, 0, 0, ALU_ADDU, 1});
        tbl.push_back('{OP_LW,    6'h00, 0, 0, 0, 5, 1, 1, 0, 0, ALU_ADDU, 1});
        tbl.push_back('{OP_SW,    6'h00, 0, 0, 3, 7, 0, 1, 0, 4, ALU_ADDU, 1});
        tbl.push_back('{OP_SW,    6'h00, 0, 0, 0, 4, 0, 1, 0, 1, ALU_ADDU, 1});
        tbl.push_back('{OP_BEQ,   6'h00, 1, 0, 0, 3, 0, 2, 0, 0, ALU_SUBU, 0});
        tbl.push_back('{OP_BEQ,   6'h00, 0, 0, 0, 3, 0, 1, 0, 0, ALU_SUBU, 0});
        tbl.push_back('{OP_J,     6'h00, 0, 0, 0, 3, 0, 2, 0, 0, ALU_ADDU, 0});
        tbl.push_back('{6'h3f,    6'h00, 0, 0, 0, 3, 0, 1, 1, 0, ALU_ADDU, 0});
        tbl.push_back('{OP_R,     6'h00, 0, 0, 0, 3, 0, 1, 1, 0, ALU_ADDU, 0});
        tbl.push_back('{OP_R,     6'h21, 0, 2, 0, 6, 1, 1, 0, 0, ALU_ADDU, 0});

        // Reset: two cycles, no enables, state parked in FETCH
        rst = 1; mem_ready = 1; op = OP_R; funct = 6'h21; zero = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_enables", 32'({pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, ill_inst}), 32'd0);
            check("rst_state", 32'(state), 32'(ST_FETCH));
            @(posedge clk); #1;
        end
        rst = 0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].z, tbl[i].fs, tbl[i].ms,
                      lat, regw, pcw, illc, mwr, alu2, ext2);
            check("tbl_latency", 32'(lat),  32'(tbl[i].lat));
            check("tbl_reg_wr",  32'(regw), 32'(tbl[i].regw));
            check("tbl_pc_wr",   32'(pcw),  32'(tbl[i].pcw));
            check("tbl_ill",     32'(illc), 32'(tbl[i].illc));
            check("tbl_mem_wr",  32'(mwr),  32'(tbl[i].mwr));
            check("tbl_aluop",   32'(alu2), 32'(tbl[i].alu2));
            check("tbl_ext_op",  32'(ext2), 32'(tbl[i].ext2));
        end

        // Reset arriving while a store waits on mem_ready
        op = OP_SW; funct = 6'h00; mem_ready = 1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 0;
        @(negedge clk);
        check("sw_in_mem_wr", 32'({state, mem_wr}), 32'({ST_MWR, 1'b1}));
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("rst_mem_wr", 32'({pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, ill_inst}), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_abort_state", 32'(state), 32'(ST_FETCH));
        @(posedge clk); #1;
        run_instr(OP_R, 6'h25, 0, 0, 0, lat, regw, pcw, illc, mwr, alu2, ext2);
        check("post_rst_latency", 32'(lat), 32'd4);

        // Randomized instruction stream against the trace model
        ops = '{OP_R, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, 6'h00};
        fns = '{6'h21, 6'h23, 6'h20, 6'h24, 6'h25, 6'h2a, 6'h00};
        for (int n = 0; n < 200; n++) begin
            logic [5:0] ro, rf;
            int sel;
            sel = $urandom_range(0, 9);
            ro  = (sel == 9) ? 6'($urandom) : ops[sel];
            sel = $urandom_range(0, 7);
            rf  = (sel == 7) ? 6'($urandom) : fns[sel];
            run_instr(ro, rf, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                      lat, regw, pcw, illc, mwr, alu2, ext2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
